// File: rtl/corral_pkg.sv
`default_nettype none
// Shared types and limits for the Corral turn sequencer.
package corral_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SETTLE = 2'd2
  } turn_state_t;

  localparam logic [2:0] MOVE_MIN  = 3'd1;
  localparam logic [2:0] MOVE_MAX  = 3'd5;
  localparam logic [5:0] TURN_MAX  = 6'd63;
  localparam logic [3:0] TALLY_MAX = 4'd15;

  function automatic logic is_legal(input logic [2:0] m);
    return (m >= MOVE_MIN) && (m <= MOVE_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/corral_debounce.sv
`default_nettype none
// Two-flop synchronizer followed by a counter debouncer; the level follows the
// synchronized input only after CYCLES consecutive cycles of a stable new value.
module corral_debounce #(
  parameter int WIDTH  = 1,
  parameter int CYCLES = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [WIDTH-1:0] sync1, sync2, sync3;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    base;
  logic             differ;
  logic             changed;

  // A change in the synchronized value restarts the stability count.
  always_comb begin
    differ  = (sync2 != level);
    changed = (sync2 != sync3);
    base    = changed ? '0 : cnt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      level <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      sync3 <= sync2;
      if (!differ) begin
        cnt <= '0;
      end else if (base == CW'(CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= base + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/corral_turn_ctrl.sv
`default_nettype none
// Corral turn sequencer: conditions pad inputs, validates moves, pulses the
// core's enter/move with a ready handshake and keeps turn and score tallies.
module corral_turn_ctrl
  import corral_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_enter,
  input  logic [2:0] sw_move,
  input  logic       game_ready,
  input  logic       game_over,
  input  logic       game_lostwon,
  output logic       enter,
  output logic [2:0] move,
  output logic [5:0] turn_count,
  output logic [3:0] wins,
  output logic [3:0] losses,
  output logic       illegal_move,
  output logic       timeout,
  output logic       busy
);

  localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic             btn_level;
  logic             btn_prev;
  logic             press;
  logic [2:0]       move_level;
  turn_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept;
  logic             reject;
  logic             timeout_hit;
  logic             go_prev;
  logic             go_rise;
  logic             new_round;

  corral_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clock (clock),
    .reset (reset),
    .raw   (btn_enter),
    .level (btn_level)
  );

  corral_debounce #(.WIDTH(3), .CYCLES(DEBOUNCE_CYCLES)) u_move_db (
    .clock (clock),
    .reset (reset),
    .raw   (sw_move),
    .level (move_level)
  );

  assign press   = btn_level & ~btn_prev;
  assign go_rise = game_over & ~go_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // One counter serves both the hold length and the settle timeout.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    accept      = 1'b0;
    reject      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press && game_ready) begin
          if (is_legal(move_level)) begin
            accept     = 1'b1;
            state_next = ST_HOLD;
            cnt_next   = '0;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          state_next = ST_SETTLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (game_ready) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_next  = ST_IDLE;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_prev     <= 1'b0;
      go_prev      <= 1'b0;
      enter        <= 1'b0;
      move         <= 3'd0;
      turn_count   <= 6'd0;
      wins         <= 4'd0;
      losses       <= 4'd0;
      illegal_move <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
      new_round    <= 1'b0;
    end else begin
      btn_prev     <= btn_level;
      go_prev      <= game_over;
      enter        <= (state_next == ST_HOLD);
      busy         <= (state_next != ST_IDLE);
      illegal_move <= reject;
      timeout      <= timeout | timeout_hit;

      if (accept) begin
        move <= move_level;
        if (new_round)
          turn_count <= 6'd1;
        else if (turn_count != TURN_MAX)
          turn_count <= turn_count + 1'b1;
      end

      // A round ending in the same cycle as an accept marks the following move as round start.
      if (go_rise) begin
        new_round <= 1'b1;
        if (game_lostwon) begin
          if (wins != TALLY_MAX) wins <= wins + 1'b1;
        end else begin
          if (losses != TALLY_MAX) losses <= losses + 1'b1;
        end
      end else if (accept) begin
        new_round <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_corral_turn_ctrl.sv
`default_nettype none
// Directed self-checking bench for corral_turn_ctrl (DEBOUNCE=4, HOLD=2, TIMEOUT=16).
module tb_corral_turn_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_enter;
  logic [2:0] sw_move;
  logic       game_ready;
  logic       game_over;
  logic       game_lostwon;
  logic       enter;
  logic [2:0] move;
  logic [5:0] turn_count;
  logic [3:0] wins;
  logic [3:0] losses;
  logic       illegal_move;
  logic       timeout;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  corral_turn_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (2),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .btn_enter    (btn_enter),
    .sw_move      (sw_move),
    .game_ready   (game_ready),
    .game_over    (game_over),
    .game_lostwon (game_lostwon),
    .enter        (enter),
    .move         (move),
    .turn_count   (turn_count),
    .wins         (wins),
    .losses       (losses),
    .illegal_move (illegal_move),
    .timeout      (timeout),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_move(input logic [2:0] m);
    sw_move = m;
    tick(10);
  endtask

  task automatic release_btn();
    btn_enter = 1'b0;
    tick(10);
  endtask

  // Button already high at relative cycle 0; enter expected high at cycles 7 and 8.
  task automatic watch_accept(input string tag);
    for (int t = 1; t <= 11; t++) begin
      tick(1);
      check(tag, enter, (t == 7 || t == 8));
    end
  endtask

  task automatic watch_reject(input string tag, input logic exp_illegal);
    for (int t = 1; t <= 11; t++) begin
      tick(1);
      check({tag, "_enter"}, enter, 1'b0);
      check({tag, "_illegal"}, illegal_move, exp_illegal && (t == 7));
    end
  endtask

  initial begin
    reset = 1'b1; btn_enter = 1'b0; sw_move = 3'd0;
    game_ready = 1'b1; game_over = 1'b0; game_lostwon = 1'b0;
    tick(3);
    check("rst_enter", enter, 1'b0);
    check("rst_move", move, 3'd0);
    check("rst_turn", turn_count, 6'd0);
    check("rst_wins", wins, 4'd0);
    check("rst_losses", losses, 4'd0);
    check("rst_illegal", illegal_move, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick(2);

    // Clean press, move 3
    set_move(3'd3);
    btn_enter = 1'b1;
    watch_accept("clean_enter");
    check("clean_move", move, 3'd3);
    check("clean_turn", turn_count, 6'd1);
    check("clean_busy", busy, 1'b0);
    release_btn();

    // Bouncing button 1,0,1 then stable; timed from final rise
    set_move(3'd2);
    btn_enter = 1'b1; tick(2);
    btn_enter = 1'b0; tick(2);
    btn_enter = 1'b1;
    watch_accept("bounce_enter");
    check("bounce_move", move, 3'd2);
    check("bounce_turn", turn_count, 6'd2);
    release_btn();

    // Illegal moves 6 and 0
    set_move(3'd6);
    btn_enter = 1'b1;
    watch_reject("ill6", 1'b1);
    release_btn();
    set_move(3'd0);
    btn_enter = 1'b1;
    watch_reject("ill0", 1'b1);
    release_btn();
    check("ill_turn", turn_count, 6'd2);
    check("ill_move", move, 3'd2);

    // Press while core not ready is ignored
    game_ready = 1'b0;
    set_move(3'd4);
    btn_enter = 1'b1;
    watch_reject("notready", 1'b0);
    release_btn();
    game_ready = 1'b1;
    check("notready_turn", turn_count, 6'd2);

    // Ready never returns: timeout at SETTLE + 16
    btn_enter = 1'b1;
    tick(7);
    check("to_enter", enter, 1'b1);
    game_ready = 1'b0;
    tick(17);
    check("to_before", timeout, 1'b0);
    check("to_busy_before", busy, 1'b1);
    tick(1);
    check("to_set", timeout, 1'b1);
    check("to_idle", busy, 1'b0);
    game_ready = 1'b1;
    release_btn();
    check("to_sticky", timeout, 1'b1);
    check("to_turn", turn_count, 6'd3);

    // Win arrives mid-HOLD; pulse stays intact
    set_move(3'd5);
    btn_enter = 1'b1;
    tick(7);
    check("win_enter7", enter, 1'b1);
    check("win_before", wins, 4'd0);
    game_lostwon = 1'b1;
    game_over = 1'b1;
    tick(1);
    check("win_score", wins, 4'd1);
    check("win_enter8", enter, 1'b1);
    tick(1);
    check("win_enter9", enter, 1'b0);
    check("win_turn", turn_count, 6'd4);
    check("win_move", move, 3'd5);
    game_over = 1'b0;
    release_btn();

    // First move of the new round restarts the turn count
    set_move(3'd1);
    btn_enter = 1'b1;
    watch_accept("newround_enter");
    check("newround_turn", turn_count, 6'd1);
    release_btn();
    set_move(3'd3);
    btn_enter = 1'b1;
    watch_accept("round2_enter");
    check("round2_turn", turn_count, 6'd2);
    release_btn();

    // Win saturation and a loss
    repeat (15) begin
      game_over = 1'b1; tick(2);
      game_over = 1'b0; tick(2);
    end
    check("wins_sat", wins, 4'd15);
    check("losses_none", losses, 4'd0);
    game_lostwon = 1'b0;
    game_over = 1'b1;
    tick(1);
    check("loss_score", losses, 4'd1);
    check("wins_hold", wins, 4'd15);
    game_over = 1'b0;
    tick(2);

    // Reset mid-HOLD drops enter; game_over high across reset counts after release
    set_move(3'd2);
    btn_enter = 1'b1;
    tick(7);
    check("rh_enter", enter, 1'b1);
    reset = 1'b1;
    game_over = 1'b1;
    game_lostwon = 1'b0;
    btn_enter = 1'b0;
    tick(1);
    check("rh_drop", enter, 1'b0);
    check("rh_busy", busy, 1'b0);
    check("rh_timeout", timeout, 1'b0);
    check("rh_wins", wins, 4'd0);
    check("rh_turn", turn_count, 6'd0);
    tick(2);
    reset = 1'b0;
    check("rel_losses0", losses, 4'd0);
    tick(1);
    check("rel_losses1", losses, 4'd1);
    check("rel_wins", wins, 4'd0);
    tick(2);
    check("rel_losses_once", losses, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/corral_turn_ctrl.md
# corral_turn_ctrl

Turn sequencer for the Corral game core. It synchronizes and debounces the player's raw enter button and move switches, and checks that the move is legal. It then drives the core's `enter`/`move` inputs with a fixed-length pulse, handshaking against the core's `ready` output. It also keeps per-round turn count and win/loss tallies for the display logic. It sits between the top-level pad inputs and `game`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable cycles required before a debounced level changes (≥1).
- `HOLD_CYCLES`, default 2: cycles `enter` is held high per accepted move (≥2).
- `TIMEOUT_CYCLES`, default 4096: maximum cycles to wait for `game_ready` to return after a move.

Ports:
- `clock` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `btn_enter` in 1: raw, asynchronous enter button.
- `sw_move` in 3: raw, asynchronous move switches.
- `game_ready` in 1: core idle and accepting a move.
- `game_over` in 1: core gameover flag.
- `game_lostwon` in 1: core result; 1 = horse caught (win), 0 = kicked out (loss).
- `enter` out 1: to core.
- `move` out 3: to core; stable whenever `enter` is high.
- `turn_count` out 6: moves accepted in the current round; saturates at 63.
- `wins` out 4 and `losses` out 4: round tallies; each saturates at 15.
- `illegal_move` out 1: one-cycle pulse when a press is rejected.
- `timeout` out 1: sticky error flag; cleared only by reset.
- `busy` out 1: high in every state other than IDLE.

## Operation
Input conditioning:
- `btn_enter` and `sw_move` each pass through a 2-flop synchronizer, then a debouncer.
- A debounced level changes only after the synchronized value has differed from it for exactly `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
- `press` is a one-cycle pulse on the rising edge of the debounced button.

State machine (states IDLE, HOLD, SETTLE):
- IDLE
  - On `press` with `game_ready`=1 and debounced move in 1..5: latch `move`, go to HOLD, increment `turn_count`.
  - On `press` with `game_ready`=1 and move 0, 6 or 7: pulse `illegal_move`, stay in IDLE.
  - On `press` with `game_ready`=0: ignore the press; no pulse.
- HOLD
  - `enter`=1 for exactly `HOLD_CYCLES` cycles, then go to SETTLE.
- SETTLE
  - `enter`=0; wait for `game_ready`=1, then go to IDLE.
  - If `game_ready` does not return within `TIMEOUT_CYCLES` cycles: set `timeout`, go to IDLE.
  - Presses in HOLD and SETTLE are discarded, not queued.

Scoring:
- On a `game_over` rising edge (registered previous value), increment `wins` if `game_lostwon`=1, else `losses`. This happens in any state, including mid-HOLD.
- The same edge sets an internal `new_round` flag.
- The next accepted move loads `turn_count`=1 (not +1) and clears `new_round`.

Reset:
- All outputs are 0 and the state is IDLE.
- Synchronizer, debouncer levels and counters are cleared.
- `game_over` prev is cleared, so a `game_over` already high when reset is released counts as a rising edge one cycle later.
- Reset mid-HOLD drops `enter` on the next edge.

## Timing
- Latency: `btn_enter` rises at cycle 0 and stays stable → debounced level high at cycle 2+`DEBOUNCE_CYCLES` → `enter` high from cycle 3+`DEBOUNCE_CYCLES` for `HOLD_CYCLES` cycles.
- `move` is registered at the HOLD transition and held until the next accepted move.
- `illegal_move` is asserted in the cycle after `press`.
- The score update is visible 1 cycle after the `game_over` edge is sampled.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- `corral_pkg`: state enum `turn_state_t`, constants `MOVE_MIN`=1 and `MOVE_MAX`=5, saturation limits.
- Sub-module `corral_debounce #(WIDTH, CYCLES)`: synchronizer plus debouncer. Instantiated twice, WIDTH=1 for the button and WIDTH=3 for the switches.
- FSM, counters and scoring live in `corral_turn_ctrl`.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, HOLD_CYCLES=2, TIMEOUT_CYCLES=16.
- Clean press, `sw_move`=3, `game_ready`=1 → `enter` high at cycles 7–8 only, `move`=3, `turn_count`=1, then IDLE once `game_ready` returns.
- Button bounces 1,0,1 with 2-cycle gaps, then stays high → exactly one `enter` pulse, timed from the last rising transition.
- `sw_move`=6 → `illegal_move` 1-cycle pulse, no `enter`. `sw_move`=0 → same response.
- Press while `game_ready`=0 → no `enter` and no `illegal_move`.
- After `enter`, `game_ready` held at 0 → `timeout`=1 at SETTLE+16 and state returns to IDLE. `timeout` stays 1 until reset.
- `game_over` rises with `game_lostwon`=1 during HOLD → `wins`=1 and `enter` pulse completes intact. The next accepted move gives `turn_count`=1. Driving 16 wins gives `wins` saturated at 15.
